// File: rtl/ascii_stream_pkg.sv
// rtl/ascii_stream_pkg.sv - shared constants, FSM states and message table for the ASCII beacon stream
//
// Purpose : definitions shared by the beacon transmitter and the receive-side checker.
// Ports   : none (package).
package ascii_stream_pkg;

   localparam int         MSG_LEN = 16;
   localparam logic [7:0] NUL     = 8'h00;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   // "siliconpr0n.org" followed by the NUL terminator at index 15.
   function automatic logic [7:0] expected_char(input logic [3:0] idx);
      logic [7:0] c;
      case (idx)
         4'd0:    c = 8'h73; // s
         4'd1:    c = 8'h69; // i
         4'd2:    c = 8'h6C; // l
         4'd3:    c = 8'h69; // i
         4'd4:    c = 8'h63; // c
         4'd5:    c = 8'h6F; // o
         4'd6:    c = 8'h6E; // n
         4'd7:    c = 8'h70; // p
         4'd8:    c = 8'h72; // r
         4'd9:    c = 8'h30; // 0
         4'd10:   c = 8'h6E; // n
         4'd11:   c = 8'h2E; // .
         4'd12:   c = 8'h6F; // o
         4'd13:   c = 8'h72; // r
         4'd14:   c = 8'h67; // g
         default: c = NUL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ascii_stream_checker_if.sv
// rtl/ascii_stream_checker_if.sv - character stream bundle between beacon source and checker
//
// Purpose : groups the per-clock character stream.
// Signals : ena     - sample qualifier
//           char_in - received 8-bit ASCII character
// Modports: master (source side), slave (checker side).
interface ascii_stream_checker_if;
   logic       ena;
   logic [7:0] char_in;

   modport master (output ena, output char_in);
   modport slave  (input  ena, input  char_in);
endinterface

// File: rtl/ascii_msg_rom.sv
// rtl/ascii_msg_rom.sv - combinational index-to-character lookup of the beacon message
//
// Purpose : maps a 4-bit message index to its expected ASCII character.
// Ports   : idx_i  - message index 0..15
//           char_o - expected character at that index
module ascii_msg_rom
   import ascii_stream_pkg::*;
(
   input  logic [3:0] idx_i,
   output logic [7:0] char_o
);

   always_comb begin
      char_o = expected_char(idx_i);
   end

endmodule

// File: rtl/ascii_stream_checker.sv
// rtl/ascii_stream_checker.sv - receive-side alignment, compare and lock checker for the beacon stream
//
// Purpose : hunts for the NUL terminator, then checks every character against the
//           message, declares lock after LOCK_FRAMES clean frames and counts
//           good frames and mismatches.
// Ports   : clk, rst_n      - clock, synchronous active-low reset
//           rx (slave)      - ena / char_in character stream
//           err_clr         - clears err_cnt, frame_cnt and the capture registers
//           locked          - aligned and LOCK_FRAMES clean frames seen
//           char_idx        - expected index of the next character
//           frame_ok        - one-cycle pulse, complete frame matched
//           mismatch        - one-cycle pulse, aligned character mismatched
//           err_cnt         - saturating mismatch count
//           frame_cnt       - wrapping good-frame count
//           cap_valid/cap_idx/cap_char - first-mismatch capture
// Macro   : STREAM_CHECK_CAPTURE_EN builds the capture registers; otherwise cap_* are 0.
module ascii_stream_checker
   import ascii_stream_pkg::*;
#(
   parameter int LOCK_FRAMES = 2,
   parameter int ERR_W       = 8,
   parameter int FRM_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ascii_stream_checker_if.slave rx,
   input  logic                  err_clr,
   output logic                  locked,
   output logic [3:0]            char_idx,
   output logic                  frame_ok,
   output logic                  mismatch,
   output logic [ERR_W-1:0]      err_cnt,
   output logic [FRM_W-1:0]      frame_cnt,
   output logic                  cap_valid,
   output logic [3:0]            cap_idx,
   output logic [7:0]            cap_char
);

   localparam logic [1:0] S_HUNT   = HUNT;
   localparam logic [1:0] S_TRACK  = TRACK;
   localparam logic [1:0] S_LOCKED = LOCKED;
   localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

   logic [1:0]       state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic             locked_q, locked_d;
   logic             frame_ok_q, frame_ok_d;
   logic             mismatch_q, mismatch_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [FRM_W-1:0] frm_q, frm_d;
   logic [3:0]       clean_q, clean_d;
   logic [7:0]       exp_char;

   ascii_msg_rom u_rom (
      .idx_i  (idx_q),
      .char_o (exp_char)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      locked_d   = locked_q;
      frame_ok_d = 1'b0;
      mismatch_d = 1'b0;
      err_d      = err_q;
      frm_d      = frm_q;
      clean_d    = clean_q;
      if (rx.ena) begin
         if (state_q == S_HUNT) begin
            // Non-NUL characters while hunting are not errors: we are not aligned yet.
            if (rx.char_in == NUL) begin
               state_d = S_TRACK;
               idx_d   = 4'd0;
            end
         end else if (rx.char_in == exp_char) begin
            if (idx_q == 4'd15) begin
               frame_ok_d = 1'b1;
               frm_d      = frm_q + 1'b1;
               idx_d      = 4'd0;
               if (clean_q != LOCK_N) begin
                  clean_d = clean_q + 4'd1;
               end
               if (clean_d == LOCK_N) begin
                  state_d  = S_LOCKED;
                  locked_d = 1'b1;
               end
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end else begin
            mismatch_d = 1'b1;
            if (err_q != '1) begin
               err_d = err_q + 1'b1;
            end
            clean_d  = 4'd0;
            locked_d = 1'b0;
            idx_d    = 4'd0;
            // A stray NUL is itself a valid frame boundary, so realign on it directly.
            state_d  = (rx.char_in == NUL) ? S_TRACK : S_HUNT;
         end
      end
      // Clear overrides any count update in the same cycle; pulses are unaffected.
      if (err_clr) begin
         err_d = '0;
         frm_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_HUNT;
         idx_q      <= 4'd0;
         locked_q   <= 1'b0;
         frame_ok_q <= 1'b0;
         mismatch_q <= 1'b0;
         err_q      <= '0;
         frm_q      <= '0;
         clean_q    <= 4'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         locked_q   <= locked_d;
         frame_ok_q <= frame_ok_d;
         mismatch_q <= mismatch_d;
         err_q      <= err_d;
         frm_q      <= frm_d;
         clean_q    <= clean_d;
      end
   end

`ifdef STREAM_CHECK_CAPTURE_EN
   logic       cap_valid_q;
   logic [3:0] cap_idx_q;
   logic [7:0] cap_char_q;

   always_ff @(posedge clk) begin
      if (!rst_n || err_clr) begin
         cap_valid_q <= 1'b0;
         cap_idx_q   <= 4'd0;
         cap_char_q  <= 8'h00;
      end else if (mismatch_d && !cap_valid_q) begin
         // Only the first mismatch is kept; later ones leave the capture alone.
         cap_valid_q <= 1'b1;
         cap_idx_q   <= idx_q;
         cap_char_q  <= rx.char_in;
      end
   end

   assign cap_valid = cap_valid_q;
   assign cap_idx   = cap_idx_q;
   assign cap_char  = cap_char_q;
`else
   assign cap_valid = 1'b0;
   assign cap_idx   = 4'd0;
   assign cap_char  = 8'h00;
`endif

   assign locked    = locked_q;
   assign char_idx  = idx_q;
   assign frame_ok  = frame_ok_q;
   assign mismatch  = mismatch_q;
   assign err_cnt   = err_q;
   assign frame_cnt = frm_q;

endmodule

// File: tb/tb_ascii_stream_checker.sv
// tb/tb_ascii_stream_checker.sv - directed self-checking bench for ascii_stream_checker
module tb_ascii_stream_checker;
   import ascii_stream_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       err_clr;
   logic       locked;
   logic [3:0] char_idx;
   logic       frame_ok;
   logic       mismatch;
   logic [7:0] err_cnt;
   logic [7:0] frame_cnt;
   logic       cap_valid;
   logic [3:0] cap_idx;
   logic [7:0] cap_char;

   int vectors;
   int miscompares;
   int exp_err;
   int exp_frm;
   logic [7:0] msg [16];

   ascii_stream_checker_if sif ();

   ascii_stream_checker #(
      .LOCK_FRAMES (2),
      .ERR_W       (8),
      .FRM_W       (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (sif.slave),
      .err_clr   (err_clr),
      .locked    (locked),
      .char_idx  (char_idx),
      .frame_ok  (frame_ok),
      .mismatch  (mismatch),
      .err_cnt   (err_cnt),
      .frame_cnt (frame_cnt),
      .cap_valid (cap_valid),
      .cap_idx   (cap_idx),
      .cap_char  (cap_char)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one sample, then observe 1 time unit after the edge that took it.
   task automatic step(input logic [7:0] c, input logic e);
      sif.char_in = c;
      sif.ena     = e;
      @(posedge clk);
      #1;
   endtask

   task automatic run_chars(input int from, input int to, output int n_mis, output int n_fok);
      n_mis = 0;
      n_fok = 0;
      for (int i = from; i <= to; i++) begin
         step(msg[i], 1'b1);
         n_mis += int'(mismatch);
         n_fok += int'(frame_ok);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(8'h00, 1'b1);
      step(8'h00, 1'b1);
      rst_n = 1'b1;
      vectors++;
      if ({locked, char_idx, frame_ok, mismatch, err_cnt, frame_cnt} !== 24'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want 0", {locked, char_idx, frame_ok, mismatch, err_cnt, frame_cnt});
      end
      vectors++;
      if ({cap_valid, cap_idx, cap_char} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_capture: got %h want 0", {cap_valid, cap_idx, cap_char});
      end
      vectors++;
      if (dut.state_q !== HUNT) begin
         miscompares++;
         $display("FAIL reset_state: got %0d want %0d", dut.state_q, HUNT);
      end
   endtask

   task automatic test_align_lock();
      int n_mis, n_fok;
      run_chars(4, 14, n_mis, n_fok);
      vectors++;
      if (n_mis !== 0 || char_idx !== 4'd0 || dut.state_q !== HUNT) begin
         miscompares++;
         $display("FAIL hunt_no_err: mis=%0d idx=%0d st=%0d want 0 0 %0d", n_mis, char_idx, dut.state_q, HUNT);
      end
      step(msg[15], 1'b1);
      vectors++;
      if (dut.state_q !== TRACK || char_idx !== 4'd0 || mismatch !== 1'b0) begin
         miscompares++;
         $display("FAIL nul_align: st=%0d idx=%0d mis=%b want %0d 0 0", dut.state_q, char_idx, mismatch, TRACK);
      end
      run_chars(0, 15, n_mis, n_fok);
      exp_frm++;
      vectors++;
      if (n_mis !== 0 || n_fok !== 1 || frame_ok !== 1'b1 || locked !== 1'b0 || frame_cnt !== 8'(exp_frm)) begin
         miscompares++;
         $display("FAIL frame1: mis=%0d fok=%0d lk=%b frm=%0d want 0 1 0 %0d", n_mis, n_fok, locked, frame_cnt, exp_frm);
      end
      run_chars(0, 15, n_mis, n_fok);
      exp_frm++;
      vectors++;
      if (n_mis !== 0 || locked !== 1'b1 || frame_cnt !== 8'd2 || err_cnt !== 8'd0 || dut.state_q !== LOCKED) begin
         miscompares++;
         $display("FAIL lock: mis=%0d lk=%b frm=%0d err=%0d st=%0d want 0 1 2 0 %0d", n_mis, locked, frame_cnt, err_cnt, dut.state_q, LOCKED);
      end
   endtask

   task automatic test_corrupt_char();
      int n_mis, n_fok;
      run_chars(0, 8, n_mis, n_fok);
      step(8'h4F, 1'b1);
      exp_err++;
      vectors++;
      if (mismatch !== 1'b1 || err_cnt !== 8'(exp_err) || locked !== 1'b0 || dut.state_q !== HUNT || char_idx !== 4'd0) begin
         miscompares++;
         $display("FAIL corrupt: mis=%b err=%0d lk=%b st=%0d idx=%0d want 1 %0d 0 %0d 0", mismatch, err_cnt, locked, dut.state_q, char_idx, exp_err, HUNT);
      end
`ifdef STREAM_CHECK_CAPTURE_EN
      vectors++;
      if (cap_valid !== 1'b1 || cap_idx !== 4'd9 || cap_char !== 8'h4F) begin
         miscompares++;
         $display("FAIL capture: v=%b idx=%0d ch=%h want 1 9 4f", cap_valid, cap_idx, cap_char);
      end
`else
      vectors++;
      if ({cap_valid, cap_idx, cap_char} !== 13'd0) begin
         miscompares++;
         $display("FAIL capture_tied: got %h want 0", {cap_valid, cap_idx, cap_char});
      end
`endif
      run_chars(10, 15, n_mis, n_fok);
      vectors++;
      if (n_mis !== 0 || dut.state_q !== TRACK || char_idx !== 4'd0) begin
         miscompares++;
         $display("FAIL corrupt_realign: mis=%0d st=%0d idx=%0d want 0 %0d 0", n_mis, dut.state_q, char_idx, TRACK);
      end
      run_chars(0, 15, n_mis, n_fok);
      run_chars(0, 15, n_mis, n_fok);
      exp_frm += 2;
      vectors++;
      if (locked !== 1'b1 || frame_cnt !== 8'(exp_frm) || err_cnt !== 8'(exp_err)) begin
         miscompares++;
         $display("FAIL relock: lk=%b frm=%0d err=%0d want 1 %0d %0d", locked, frame_cnt, err_cnt, exp_frm, exp_err);
      end
   endtask

   task automatic test_nul_resync();
      int n_mis, n_fok;
      run_chars(0, 4, n_mis, n_fok);
      step(8'h00, 1'b1);
      exp_err++;
      vectors++;
      if (mismatch !== 1'b1 || err_cnt !== 8'(exp_err) || dut.state_q !== TRACK || char_idx !== 4'd0 || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL nul_resync: mis=%b err=%0d st=%0d idx=%0d lk=%b want 1 %0d %0d 0 0", mismatch, err_cnt, dut.state_q, char_idx, locked, exp_err, TRACK);
      end
      step(msg[0], 1'b1);
      vectors++;
      if (char_idx !== 4'd1 || mismatch !== 1'b0) begin
         miscompares++;
         $display("FAIL resync_next: idx=%0d mis=%b want 1 0", char_idx, mismatch);
      end
      run_chars(1, 15, n_mis, n_fok);
      exp_frm++;
      vectors++;
      if (n_mis !== 0 || frame_ok !== 1'b1 || locked !== 1'b0 || frame_cnt !== 8'(exp_frm)) begin
         miscompares++;
         $display("FAIL resync_frame: mis=%0d fok=%b lk=%b frm=%0d want 0 1 0 %0d", n_mis, frame_ok, locked, frame_cnt, exp_frm);
      end
      run_chars(0, 15, n_mis, n_fok);
      exp_frm++;
      vectors++;
      if (locked !== 1'b1 || frame_cnt !== 8'(exp_frm)) begin
         miscompares++;
         $display("FAIL resync_relock: lk=%b frm=%0d want 1 %0d", locked, frame_cnt, exp_frm);
      end
   endtask

   task automatic test_ena_stall();
      int n_mis, n_fok;
      run_chars(0, 6, n_mis, n_fok);
      for (int k = 0; k < 3; k++) begin
         step(8'hFF, 1'b0);
         vectors++;
         if (char_idx !== 4'd7 || frame_ok !== 1'b0 || mismatch !== 1'b0 || locked !== 1'b1 ||
             err_cnt !== 8'(exp_err) || frame_cnt !== 8'(exp_frm)) begin
            miscompares++;
            $display("FAIL ena_hold%0d: idx=%0d fok=%b mis=%b lk=%b err=%0d frm=%0d want 7 0 0 1 %0d %0d",
                     k, char_idx, frame_ok, mismatch, locked, err_cnt, frame_cnt, exp_err, exp_frm);
         end
      end
      run_chars(7, 15, n_mis, n_fok);
      exp_frm++;
      vectors++;
      if (n_mis !== 0 || n_fok !== 1 || locked !== 1'b1 || frame_cnt !== 8'(exp_frm)) begin
         miscompares++;
         $display("FAIL ena_resume: mis=%0d fok=%0d lk=%b frm=%0d want 0 1 1 %0d", n_mis, n_fok, locked, frame_cnt, exp_frm);
      end
   endtask

   task automatic test_saturate_clear();
      int pulses;
      pulses = 0;
      // Each NUL at index 0 is a mismatch that resyncs straight back to index 0.
      for (int k = 0; k < 300; k++) begin
         step(8'h00, 1'b1);
         pulses += int'(mismatch);
      end
      vectors++;
      if (err_cnt !== 8'd255 || pulses !== 300 || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL err_saturate: err=%0d pulses=%0d lk=%b want 255 300 0", err_cnt, pulses, locked);
      end
      err_clr = 1'b1;
      step(8'h00, 1'b1);
      err_clr = 1'b0;
      vectors++;
      if (mismatch !== 1'b1 || err_cnt !== 8'd0 || frame_cnt !== 8'd0 || cap_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_wins: mis=%b err=%0d frm=%0d capv=%b want 1 0 0 0", mismatch, err_cnt, frame_cnt, cap_valid);
      end
      step(8'h00, 1'b1);
      vectors++;
      if (err_cnt !== 8'd1 || mismatch !== 1'b1) begin
         miscompares++;
         $display("FAIL post_clr: err=%0d mis=%b want 1 1", err_cnt, mismatch);
      end
`ifdef STREAM_CHECK_CAPTURE_EN
      vectors++;
      if (cap_valid !== 1'b1 || cap_idx !== 4'd0 || cap_char !== 8'h00) begin
         miscompares++;
         $display("FAIL recapture: v=%b idx=%0d ch=%h want 1 0 00", cap_valid, cap_idx, cap_char);
      end
`endif
      exp_frm = 0;
   endtask

   task automatic test_reset_midframe();
      int n_mis, n_fok;
      run_chars(0, 15, n_mis, n_fok);
      run_chars(0, 15, n_mis, n_fok);
      vectors++;
      if (locked !== 1'b1 || frame_cnt !== 8'd2) begin
         miscompares++;
         $display("FAIL pre_reset_lock: lk=%b frm=%0d want 1 2", locked, frame_cnt);
      end
      run_chars(0, 5, n_mis, n_fok);
      rst_n = 1'b0;
      step(msg[6], 1'b1);
      rst_n = 1'b1;
      vectors++;
      if ({locked, char_idx, frame_ok, mismatch, err_cnt, frame_cnt} !== 24'd0 ||
          {cap_valid, cap_idx, cap_char} !== 13'd0 || dut.state_q !== HUNT) begin
         miscompares++;
         $display("FAIL midframe_reset: out=%h cap=%h st=%0d want 0 0 %0d",
                  {locked, char_idx, frame_ok, mismatch, err_cnt, frame_cnt}, {cap_valid, cap_idx, cap_char}, dut.state_q, HUNT);
      end
      run_chars(7, 14, n_mis, n_fok);
      vectors++;
      if (n_mis !== 0 || dut.state_q !== HUNT || char_idx !== 4'd0) begin
         miscompares++;
         $display("FAIL post_reset_hunt: mis=%0d st=%0d idx=%0d want 0 %0d 0", n_mis, dut.state_q, char_idx, HUNT);
      end
      step(msg[15], 1'b1);
      run_chars(0, 15, n_mis, n_fok);
      vectors++;
      if (n_mis !== 0 || frame_ok !== 1'b1 || frame_cnt !== 8'd1 || locked !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_frame: mis=%0d fok=%b frm=%0d lk=%b want 0 1 1 0", n_mis, frame_ok, frame_cnt, locked);
      end
   endtask

   initial begin
      string s;
      s = "siliconpr0n.org";
      for (int i = 0; i < 15; i++) msg[i] = s[i];
      msg[15] = 8'h00;
      vectors     = 0;
      miscompares = 0;
      exp_err     = 0;
      exp_frm     = 0;
      rst_n       = 1'b0;
      err_clr     = 1'b0;
      sif.ena     = 1'b0;
      sif.char_in = 8'h00;
      #2;
      test_reset();
      test_align_lock();
      test_corrupt_char();
      test_nul_resync();
      test_ena_stall();
      test_saturate_clear();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
